// File: rtl/lsu_hs.sv
// Handshaked LSU: OUT/IN/unmapped/misaligned accesses finish in 2 cycles (o_done after accept); DMEM waits on i_mem_ack.
// Requests are taken only in IDLE and o_busy stalls the core; LSU_TIMEOUT_EN builds the ack timeout abort.
module lsu_hs #(
  parameter int N_OUT_WORDS = 16,
  parameter int N_IN_WORDS  = 2,
  parameter int DMEM_AW     = 13,
  parameter int TIMEOUT     = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  input  logic                      i_wren,
  input  logic [2:0]                i_func3,
  input  logic [31:0]               i_addr,
  input  logic [31:0]               i_st_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [31:0]               o_ld_data,
  output logic                      o_misalign,
  output logic                      o_timeout,
  output logic [DMEM_AW-1:0]        o_mem_addr,
  output logic [31:0]               o_mem_wdata,
  output logic [3:0]                o_mem_bmask,
  output logic                      o_mem_wren,
  output logic                      o_mem_rden,
  input  logic [31:0]               i_mem_rdata,
  input  logic                      i_mem_ack,
  input  logic [31:0]               i_io_sw,
  input  logic [31:0]               i_io_btn,
  output logic [32*N_OUT_WORDS-1:0] o_io_out
);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] sw_q, btn_q;
  logic [31:0] out_q [N_OUT_WORDS];
  logic [1:0]  b_q;
  logic [2:0]  f3_q;

  logic [1:0]  size, b;
  logic        misal, is_dmem, is_out, is_in;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata, out_rd, in_rd;
  logic [3:0]  out_idx;
  logic [2:0]  in_idx;

  assign size    = i_func3[1:0];
  assign b       = i_addr[1:0];
  assign is_dmem = (i_addr[15:13] == 3'b001);
  assign is_out  = (i_addr[15:6] == 10'h1C0);
  assign is_in   = (i_addr[15:5] == 11'h3C0);
  assign out_idx = i_addr[5:2] & 4'(N_OUT_WORDS - 1);
  assign in_idx  = i_addr[4:2];

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sb,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> {sb, 3'b000};
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  always_comb begin
    misal    = 1'b0;
    st_mask  = 4'b0000;
    st_wdata = i_st_data;
    case (size)
      2'b00: begin st_mask = 4'b0001 << b; st_wdata = {4{i_st_data[7:0]}}; end
      2'b01: begin
        misal    = b[0];
        st_mask  = b[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_st_data[15:0]}};
      end
      2'b10: begin misal = |b; st_mask = 4'b1111; end
      default: misal = 1'b1;
    endcase
  end

  always_comb begin
    out_rd = '0;
    for (int k = 0; k < N_OUT_WORDS; k++)
      if (out_idx == 4'(k)) out_rd = out_q[k];
    in_rd = '0;
    if (in_idx == 3'd0 && N_IN_WORDS > 0) in_rd = sw_q;
    if (in_idx == 3'd1 && N_IN_WORDS > 1) in_rd = btn_q;
  end

  for (genvar g = 0; g < N_OUT_WORDS; g++) begin : g_out
    assign o_io_out[32*g +: 32] = out_q[g];
  end

`ifdef LSU_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_q;
  assign o_timeout = to_q;
`else
  assign o_timeout = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{i_addr[31:16], TO_LAST};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      sw_q        <= '0;
      btn_q       <= '0;
      b_q         <= '0;
      f3_q        <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_ld_data   <= '0;
      o_misalign  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
      o_mem_wren  <= 1'b0;
      o_mem_rden  <= 1'b0;
      for (int k = 0; k < N_OUT_WORDS; k++) out_q[k] <= '0;
`ifdef LSU_TIMEOUT_EN
      to_cnt      <= '0;
      to_q        <= 1'b0;
`endif
    end else begin
      sw_q   <= i_io_sw;
      btn_q  <= i_io_btn;
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_req_valid) begin
          b_q  <= b;
          f3_q <= i_func3;
          if (misal || !is_dmem) begin
            // Single-cycle path: side effect and result both land on this edge.
            state      <= DONE;
            o_done     <= 1'b1;
            o_misalign <= misal;
            o_ld_data  <= '0;
            if (!misal && !i_wren) begin
              if (is_out)     o_ld_data <= extract(out_rd, b, i_func3);
              else if (is_in) o_ld_data <= extract(in_rd, b, i_func3);
            end
            if (!misal && i_wren && is_out)
              for (int k = 0; k < N_OUT_WORDS; k++)
                if (out_idx == 4'(k))
                  for (int j = 0; j < 4; j++)
                    if (st_mask[j]) out_q[k][8*j +: 8] <= st_wdata[8*j +: 8];
          end else begin
            state       <= MEM;
            o_busy      <= 1'b1;
            o_mem_addr  <= {i_addr[DMEM_AW-1:2], 2'b00};
            o_mem_wdata <= st_wdata;
            o_mem_bmask <= st_mask;
            o_mem_wren  <= i_wren;
            o_mem_rden  <= !i_wren;
`ifdef LSU_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        MEM: begin
          if (i_mem_ack) begin
            state      <= DONE;
            o_done     <= 1'b1;
            o_busy     <= 1'b0;
            o_mem_wren <= 1'b0;
            o_mem_rden <= 1'b0;
            o_ld_data  <= o_mem_rden ? extract(i_mem_rdata, b_q, f3_q) : '0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state      <= DONE;
            o_done     <= 1'b1;
            o_busy     <= 1'b0;
            o_mem_wren <= 1'b0;
            o_mem_rden <= 1'b0;
            o_ld_data  <= '0;
            to_q       <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        default: begin
          state      <= IDLE;
          o_ld_data  <= '0;
          o_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
          to_q       <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs: DMEM lanes, OUT/IN registers, misalignment, timeout, reset abort.
module tb_lsu_hs;
  logic         clk = 1'b0;
  logic         rst, req_valid, wren, mem_ack;
  logic [2:0]   func3;
  logic [31:0]  addr, st_data, mem_rdata, io_sw, io_btn;
  logic         busy, done, misalign, timeout, mem_wren, mem_rden;
  logic [31:0]  ld_data, mem_wdata;
  logic [12:0]  mem_addr;
  logic [3:0]   mem_bmask;
  logic [511:0] io_out;

  int checks = 0;
  int errors = 0;

  lsu_hs #(.N_OUT_WORDS(16), .N_IN_WORDS(2), .DMEM_AW(13), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_wren(wren), .i_func3(func3),
    .i_addr(addr), .i_st_data(st_data), .o_busy(busy), .o_done(done), .o_ld_data(ld_data),
    .o_misalign(misalign), .o_timeout(timeout), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_bmask(mem_bmask), .o_mem_wren(mem_wren), .o_mem_rden(mem_rden),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack), .i_io_sw(io_sw), .i_io_btn(io_btn),
    .o_io_out(io_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one edge; outputs are sampled 1 time unit after it.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    wren = w; func3 = f3; addr = a; st_data = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; wren = 1'b0; func3 = 3'b0; addr = '0; st_data = '0;
    mem_ack = 1'b0; mem_rdata = '0; io_sw = '0; io_btn = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_hs: done=%b busy=%b expected 0 0", done, busy); end
    checks++; if (mem_rden !== 1'b0 || mem_wren !== 1'b0) begin errors++; $display("FAIL reset_strobes: rden=%b wren=%b expected 0 0", mem_rden, mem_wren); end
    checks++; if (io_out !== 512'h0 || ld_data !== 32'h0) begin errors++; $display("FAIL reset_regs: io_out/ld_data nonzero ld=%h", ld_data); end
    checks++; if (misalign !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: mis=%b to=%b expected 0 0", misalign, timeout); end
  endtask

  task automatic test_dmem();
    issue(1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5);
    checks++; if (mem_wren !== 1'b1 || mem_rden !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sb_strobe: wren=%b rden=%b busy=%b expected 1 0 1", mem_wren, mem_rden, busy); end
    checks++; if (mem_bmask !== 4'b1000) begin errors++; $display("FAIL sb_bmask: got %b expected 1000", mem_bmask); end
    checks++; if (mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 13'h0) begin errors++; $display("FAIL sb_wdata: got %h addr %h expected a5a5a5a5 0", mem_wdata, mem_addr); end
    tick();
    checks++; if (mem_wren !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sb_hold: wren=%b done=%b expected 1 0", mem_wren, done); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || mem_wren !== 1'b0) begin errors++; $display("FAIL sb_done: done=%b busy=%b wren=%b expected 1 0 0", done, busy, mem_wren); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sb_done_pulse: done=%b expected 0", done); end

    issue(1'b0, 3'b000, 32'h0000_2003, 32'h0);
    checks++; if (mem_rden !== 1'b1 || mem_wren !== 1'b0) begin errors++; $display("FAIL lb_strobe: rden=%b wren=%b expected 1 0", mem_rden, mem_wren); end
    mem_rdata = 32'hA500_0000; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || ld_data !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lb_data: done=%b got %h expected ffffffa5", done, ld_data); end
    tick();
    issue(1'b0, 3'b100, 32'h0000_2003, 32'h0);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || ld_data !== 32'h0000_00A5) begin errors++; $display("FAIL lbu_data: done=%b got %h expected 000000a5", done, ld_data); end
    tick();
  endtask

  task automatic test_out();
    issue(1'b1, 3'b010, 32'h0000_7010, 32'h1234_5678);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sw_out_hs: done=%b busy=%b expected 1 0", done, busy); end
    checks++; if (io_out[159:128] !== 32'h1234_5678) begin errors++; $display("FAIL sw_out: got %h expected 12345678", io_out[159:128]); end
    tick();
    issue(1'b1, 3'b001, 32'h0000_7012, 32'h0000_BEEF);
    checks++; if (io_out[159:128] !== 32'hBEEF_5678) begin errors++; $display("FAIL sh_out: got %h expected beef5678", io_out[159:128]); end
    tick();
    issue(1'b0, 3'b010, 32'h0000_7010, 32'h0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || ld_data !== 32'hBEEF_5678) begin errors++; $display("FAIL lw_out: done=%b busy=%b got %h expected 1 0 beef5678", done, busy, ld_data); end
    tick();
    issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    checks++; if (done !== 1'b1 || ld_data !== 32'h0 || misalign !== 1'b0) begin errors++; $display("FAIL unmapped: done=%b got %h mis=%b expected 1 0 0", done, ld_data, misalign); end
    tick();
  endtask

  task automatic test_misalign();
    issue(1'b0, 3'b010, 32'h0000_2002, 32'h0);
    checks++; if (done !== 1'b1 || misalign !== 1'b1 || mem_rden !== 1'b0) begin errors++; $display("FAIL lw_misalign: done=%b mis=%b rden=%b expected 1 1 0", done, misalign, mem_rden); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b expected 0", misalign); end
    issue(1'b1, 3'b001, 32'h0000_7001, 32'h0000_FFFF);
    checks++; if (misalign !== 1'b1 || io_out[159:128] !== 32'hBEEF_5678 || io_out[31:0] !== 32'h0) begin errors++; $display("FAIL sh_misalign: mis=%b word4=%h word0=%h expected 1 beef5678 0", misalign, io_out[159:128], io_out[31:0]); end
    tick();
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    issue(1'b0, 3'b010, 32'h0000_2000, 32'h0);
`ifdef LSU_TIMEOUT_EN
    while (mem_rden === 1'b1 && hi < 150) begin hi++; tick(); end
    checks++; if (hi !== 4) begin errors++; $display("FAIL timeout_len: strobe cycles %0d expected 4", hi); end
    checks++; if (done !== 1'b1 || timeout !== 1'b1 || ld_data !== 32'h0 || misalign !== 1'b0) begin errors++; $display("FAIL timeout_done: done=%b to=%b ld=%h mis=%b expected 1 1 0 0", done, timeout, ld_data, misalign); end
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
`else
    for (int i = 0; i < 100; i++) tick();
    checks++; if (mem_rden !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL no_timeout_wait: rden=%b busy=%b done=%b expected 1 1 0", mem_rden, busy, done); end
    mem_rdata = 32'h0; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL no_timeout_ack: done=%b to=%b expected 1 0", done, timeout); end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'b010, 32'h0000_2000, 32'h0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (mem_rden !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid: rden=%b busy=%b done=%b expected 0 0 0", mem_rden, busy, done); end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL late_ack: done=%b expected 0", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL late_ack2: done=%b expected 0", done); end
    issue(1'b0, 3'b010, 32'h0000_2004, 32'h0);
    checks++; if (mem_rden !== 1'b1 || mem_addr !== 13'h0004) begin errors++; $display("FAIL post_rst_req: rden=%b addr=%h expected 1 0004", mem_rden, mem_addr); end
    mem_rdata = 32'h1122_3344; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    checks++; if (done !== 1'b1 || ld_data !== 32'h1122_3344) begin errors++; $display("FAIL post_rst_ld: done=%b got %h expected 11223344", done, ld_data); end
    tick();
  endtask

  task automatic test_input();
    io_sw = 32'hCAFE_0001; io_btn = 32'h0000_8001;
    tick();
    issue(1'b0, 3'b001, 32'h0000_7802, 32'h0);
    checks++; if (done !== 1'b1 || ld_data !== 32'hFFFF_CAFE) begin errors++; $display("FAIL lh_sw: got %h expected ffffcafe", ld_data); end
    tick();
    issue(1'b0, 3'b010, 32'h0000_7808, 32'h0);
    checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL lw_in2: got %h expected 0", ld_data); end
    tick();
    issue(1'b0, 3'b101, 32'h0000_7804, 32'h0);
    checks++; if (ld_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_btn: got %h expected 00008001", ld_data); end
    tick();
    issue(1'b0, 3'b001, 32'h0000_7804, 32'h0);
    checks++; if (ld_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_btn: got %h expected ffff8001", ld_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_dmem();
    test_out();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_input();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
